// File: rtl/booth_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : booth_product_accumulator
// Description : Sums frames of COUNT signed products from a Booth multiplier
//               into a wide accumulator, using valid/ready handshakes on the
//               input and output. Each completed frame sum is held until the
//               sink accepts it. A sticky flag records signed overflow.
//               Optional macro BOOTH_ACC_SAT_EN: saturate on overflow
//               instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_product_accumulator #(
    parameter int WIDTH = 9,
    parameter int COUNT = 4,
    parameter int ACC_W = 20,
    localparam int CNT_W = $clog2(COUNT + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2*WIDTH-1:0]   prod_i,
    input  logic                 prod_valid_i,
    output logic                 prod_ready_o,
    input  logic                 clear_i,
    output logic [ACC_W-1:0]     acc_o,
    output logic                 acc_valid_o,
    input  logic                 acc_ready_i,
    output logic [CNT_W-1:0]     cnt_o,
    output logic                 ovf_o
);

    localparam int               c_prod_w   = 2 * WIDTH;
    localparam logic [0:0]       c_st_acc   = 1'b0;
    localparam logic [0:0]       c_st_done  = 1'b1;
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(COUNT - 1);

    // The accumulator must be able to hold at least one full product.
    generate
        if (ACC_W < c_prod_w) begin : g_acc_w_check
            $error("booth_product_accumulator: ACC_W must be >= 2*WIDTH");
        end
        if (COUNT < 1) begin : g_count_check
            $error("booth_product_accumulator: COUNT must be >= 1");
        end
    endgenerate

    logic [0:0]       r_state;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_acc_valid;
    logic             r_ovf;

    logic [ACC_W-1:0] w_prod_ext;
    logic [ACC_W-1:0] w_sum;
    logic [ACC_W-1:0] w_acc_next;
    logic             w_ovf;
    logic             w_in_xfer;

    // Sign-extend the product to accumulator width; no extension needed
    // when the widths already match.
    generate
        if (ACC_W > c_prod_w) begin : g_sext
            assign w_prod_ext = {{(ACC_W - c_prod_w){prod_i[c_prod_w-1]}}, prod_i};
        end else begin : g_nosext
            assign w_prod_ext = prod_i;
        end
    endgenerate

    assign w_sum = r_acc + w_prod_ext;

    // Signed overflow: both addends share a sign and the sum's sign differs.
    assign w_ovf = (r_acc[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                   (w_sum[ACC_W-1] != r_acc[ACC_W-1]);

`ifdef BOOTH_ACC_SAT_EN
    // Clamp toward the extreme matching the operands' common sign.
    assign w_acc_next = !w_ovf         ? w_sum :
                        r_acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} :
                                         {1'b0, {(ACC_W-1){1'b1}}};
`else
    // Plain two's-complement wrap.
    assign w_acc_next = w_sum;
`endif

    // Products are only taken while a frame is open and no clear is pending.
    assign prod_ready_o = (r_state == c_st_acc) && !clear_i;
    assign w_in_xfer    = prod_valid_i && prod_ready_o;

    // Frame control: accumulate in ACC, hold result in DONE until accepted.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            r_state     <= c_st_acc;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_acc_valid <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                c_st_acc: begin
                    if (w_in_xfer) begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt + CNT_W'(1);
                        r_ovf <= r_ovf | w_ovf;
                        if (r_cnt == c_last_cnt) begin
                            r_state     <= c_st_done;
                            r_acc_valid <= 1'b1;
                        end
                    end
                end
                c_st_done: begin
                    if (r_acc_valid && acc_ready_i) begin
                        r_state     <= c_st_acc;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_acc_valid <= 1'b0;
                        r_ovf       <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_st_acc;
                end
            endcase
        end
    end

    assign acc_o       = r_acc;
    assign acc_valid_o = r_acc_valid;
    assign cnt_o       = r_cnt;
    assign ovf_o       = r_ovf;

endmodule
`default_nettype wire
